shift_execute_stage: RTL and testbench

Pipelined execute stage that wraps the 16-bit `BarrelShifter`. It accepts shift requests from the decode/issue stage over a valid/ready handshake and registers the operands that drive the shifter. It captures the shifted result with zero/negative/carry flags and hands it to writeback over a second valid/ready handshake. Latency is two cycles and throughput is one request per cycle, with full backpressure support.

---
 rtl/shift_pkg.sv | 24 ++
 rtl/BarrelShifter.sv | 33 +++
 rtl/shift_execute_stage.sv | 139 +++++++++++++
 tb/tb_shift_execute_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared widths, shift-op encodings and op legality helper for
//            the shift execute stage.
// Revision : 1.0
// ============================================================================
package shift_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    localparam logic [2:0] OP_LSR = 3'b000;
    localparam logic [2:0] OP_LSL = 3'b001;
    localparam logic [2:0] OP_ROR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_ASR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/BarrelShifter.sv
`default_nettype none
// ============================================================================
// Module   : BarrelShifter
// Purpose  : Combinational 16-bit shifter/rotator (LSR, LSL, ROR, ROL, ASR).
// Revision : 1.0
// ============================================================================
module BarrelShifter
    import shift_pkg::*;
(
    input  logic [2:0]        ShiftSelect,
    input  logic [AMT_W-1:0]  ShifterAmount,
    input  logic [DATA_W-1:0] OriginB,
    output logic [DATA_W-1:0] ShiftResult
);

    // 16 - amount, modulo 16; a zero amount makes both rotate halves the operand
    logic [AMT_W-1:0] w_inv_amount;
    assign w_inv_amount = {AMT_W{1'b0}} - ShifterAmount;

    always_comb begin
        ShiftResult = OriginB;
        case (ShiftSelect)
            OP_LSR:  ShiftResult = OriginB >> ShifterAmount;
            OP_LSL:  ShiftResult = OriginB << ShifterAmount;
            OP_ROR:  ShiftResult = (OriginB >> ShifterAmount) | (OriginB << w_inv_amount);
            OP_ROL:  ShiftResult = (OriginB << ShifterAmount) | (OriginB >> w_inv_amount);
            OP_ASR:  ShiftResult = $unsigned($signed(OriginB) >>> ShifterAmount);
            default: ShiftResult = OriginB;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_execute_stage
// Purpose  : Two-stage pipelined shift execute stage with valid/ready on both
//            sides, result flags and an illegal-op pulse.
// Revision : 1.0
// ============================================================================
module shift_execute_stage
    import shift_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              InValid,
    output logic              InReady,
    input  logic [2:0]        InOp,
    input  logic [AMT_W-1:0]  InAmount,
    input  logic [DATA_W-1:0] InOperand,
    input  logic [TAG_W-1:0]  InTag,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutResult,
    output logic [TAG_W-1:0]  OutTag,
    output logic              OutZero,
    output logic              OutNeg,
    output logic              OutCarry,
    output logic              IllegalOp
);

    logic [2:0]        r_op;
    logic [AMT_W-1:0]  r_amount;
    logic [DATA_W-1:0] r_operand;
    logic [TAG_W-1:0]  r_tag;
    logic              r_s1_valid;

    logic [DATA_W-1:0] r_out_result;
    logic [TAG_W-1:0]  r_out_tag;
    logic              r_out_zero;
    logic              r_out_neg;
    logic              r_out_carry;
    logic              r_out_valid;
    logic              r_illegal;

    logic              w_s1_load;
    logic              w_s2_load;
    logic              w_out_take;
    logic [DATA_W-1:0] w_shift_result;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic [AMT_W-1:0]  w_amt_m1;
    logic [AMT_W-1:0]  w_lsl_idx;

    assign InReady    = !r_s1_valid || !r_out_valid || OutReady;
    assign w_s1_load  = InValid && InReady;
    assign w_s2_load  = r_s1_valid && (!r_out_valid || OutReady);
    assign w_out_take = r_out_valid && OutReady;

    BarrelShifter u_shifter (
        .ShiftSelect   (r_op),
        .ShifterAmount (r_amount),
        .OriginB       (r_operand),
        .ShiftResult   (w_shift_result)
    );

    // Bit positions of the last bit shifted out: k-1 for right shifts, 16-k for LSL
    assign w_amt_m1  = r_amount - {{(AMT_W-1){1'b0}}, 1'b1};
    assign w_lsl_idx = {AMT_W{1'b0}} - r_amount;

    always_comb begin
        w_result = w_shift_result;
        w_carry  = 1'b0;
        if (!is_legal_op(r_op)) begin
            w_result = r_operand;
        end else if (r_amount != {AMT_W{1'b0}}) begin
            case (r_op)
                OP_LSR, OP_ASR: w_carry = r_operand[w_amt_m1];
                OP_LSL:         w_carry = r_operand[w_lsl_idx];
                OP_ROR:         w_carry = w_shift_result[DATA_W-1];
                OP_ROL:         w_carry = w_shift_result[0];
                default:        w_carry = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_op       <= '0;
            r_amount   <= '0;
            r_operand  <= '0;
            r_tag      <= '0;
            r_s1_valid <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_op       <= InOp;
                r_amount   <= InAmount;
                r_operand  <= InOperand;
                r_tag      <= InTag;
                r_s1_valid <= 1'b1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
            r_illegal <= w_s1_load && !is_legal_op(InOp);
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_out_result <= '0;
            r_out_tag    <= '0;
            r_out_zero   <= 1'b0;
            r_out_neg    <= 1'b0;
            r_out_carry  <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_out_result <= w_result;
                r_out_tag    <= r_tag;
                r_out_zero   <= (w_result == {DATA_W{1'b0}});
                r_out_neg    <= w_result[DATA_W-1];
                r_out_carry  <= w_carry;
                r_out_valid  <= 1'b1;
            end else if (w_out_take) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign OutValid  = r_out_valid;
    assign OutResult = r_out_result;
    assign OutTag    = r_out_tag;
    assign OutZero   = r_out_zero;
    assign OutNeg    = r_out_neg;
    assign OutCarry  = r_out_carry;
    assign IllegalOp = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_shift_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_execute_stage
// Purpose  : Self-checking bench: directed literal cases plus randomized
//            traffic compared every cycle against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_shift_execute_stage;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [2:0]  InOp = '0;
    logic [3:0]  InAmount = '0;
    logic [15:0] InOperand = '0;
    logic [3:0]  InTag = '0;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [15:0] OutResult;
    logic [3:0]  OutTag;
    logic        OutZero, OutNeg, OutCarry, IllegalOp;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    shift_execute_stage #(.TAG_W(4)) dut (
        .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .InOp(InOp), .InAmount(InAmount), .InOperand(InOperand), .InTag(InTag),
        .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult),
        .OutTag(OutTag), .OutZero(OutZero), .OutNeg(OutNeg),
        .OutCarry(OutCarry), .IllegalOp(IllegalOp)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] res;
        logic [3:0]  tag;
        logic        z, n, c;
        int          acc;
    } exp_t;

    // Reference: plain integer arithmetic on the shift rules
    function automatic exp_t model(input logic [2:0] op, input logic [3:0] amt,
                                   input logic [15:0] opd, input logic [3:0] tag);
        exp_t e;
        int k;
        int unsigned x, r;
        int s, t;
        logic c;
        k = int'(amt);
        x = 32'(opd);
        c = 1'b0;
        case (op)
            3'd0: begin r = x >> k; if (k > 0) c = ((x >> (k - 1)) & 1) != 0; end
            3'd1: begin r = (x << k) & 32'hFFFF; c = (((x << k) >> 16) & 1) != 0; end
            3'd2: begin r = ((x >> k) | (x << (16 - k))) & 32'hFFFF; c = (k > 0) && (((r >> 15) & 1) != 0); end
            3'd3: begin r = ((x << k) | (x >> (16 - k))) & 32'hFFFF; c = (k > 0) && ((r & 1) != 0); end
            3'd4: begin
                s = int'($signed(opd));
                t = s >>> k;
                r = 32'(t) & 32'hFFFF;
                if (k > 0) c = ((x >> (k - 1)) & 1) != 0;
            end
            default: r = x;
        endcase
        e.res = r[15:0];
        e.tag = tag;
        e.z   = (r == 0);
        e.n   = r[15];
        e.c   = c;
        e.acc = 0;
        return e;
    endfunction

    // Per-cycle compare against the model; a stage holds at most two requests
    exp_t q[$];
    logic exp_ill = 1'b0;

    always @(negedge Clk) begin
        exp_t e;
        logic exp_valid;
        if (!ResetN) begin
            q.delete();
            exp_ill = 1'b0;
        end else begin
            exp_valid = (q.size() > 0) && (q[0].acc < edges);
            check("out_valid", 32'(OutValid), 32'(exp_valid));
            check("in_ready", 32'(InReady), 32'((q.size() < 2) || OutReady));
            check("illegal_pulse", 32'(IllegalOp), 32'(exp_ill));
            if (exp_valid && OutValid) begin
                check("result", 32'(OutResult), 32'(q[0].res));
                check("tag", 32'(OutTag), 32'(q[0].tag));
                check("flags_znc", {29'd0, OutZero, OutNeg, OutCarry},
                      {29'd0, q[0].z, q[0].n, q[0].c});
            end
            if (exp_valid && OutReady) void'(q.pop_front());
            exp_ill = 1'b0;
            if (InValid && InReady) begin
                e = model(InOp, InAmount, InOperand, InTag);
                e.acc = edges + 1;
                q.push_back(e);
                exp_ill = (InOp > 3'd4);
            end
        end
    end

    task automatic do_req(input logic [2:0] op, input logic [3:0] amt, input logic [15:0] opd,
                          input logic [3:0] tag, output logic [15:0] res, output logic [3:0] rtag,
                          output logic z, output logic n, output logic c,
                          output int lat, output int ill);
        int g;
        bit found;
        @(posedge Clk); #1;
        InValid = 1'b1; InOp = op; InAmount = amt; InOperand = opd; InTag = tag; OutReady = 1'b1;
        g = 0;
        @(negedge Clk);
        while (!InReady && g < 50) begin @(negedge Clk); g++; end
        @(posedge Clk); #1;
        InValid = 1'b0;
        lat = -1; ill = 0; found = 0;
        res = '0; rtag = '0; z = 0; n = 0; c = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clk);
            ill += int'(IllegalOp);
            if (OutValid && !found) begin
                found = 1; lat = i;
                res = OutResult; rtag = OutTag; z = OutZero; n = OutNeg; c = OutCarry;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] res;
        logic [3:0]  rtag;
        logic        z, n, c;
        int          lat, ill, idx, highs;
        int          got[$];
        logic [15:0] exp_res [5];
        logic        exp_c   [5];
        bit          acc;

        exp_res[0] = 16'h6800; exp_c[0] = 1'b0;
        exp_res[1] = 16'hA000; exp_c[1] = 1'b1;
        exp_res[2] = 16'h6800; exp_c[2] = 1'b0;
        exp_res[3] = 16'hA001; exp_c[3] = 1'b1;
        exp_res[4] = 16'hE800; exp_c[4] = 1'b0;

        repeat (3) @(posedge Clk);
        #1 ResetN = 1'b1;
        @(negedge Clk);
        check("rst_out_valid", 32'(OutValid), 0);
        check("rst_in_ready", 32'(InReady), 1);
        check("rst_result", 32'(OutResult), 0);
        check("rst_illegal", 32'(IllegalOp), 0);

        // Five ops on 0xD000 by one
        for (int i = 0; i < 5; i++) begin
            do_req(3'(i), 4'd1, 16'hD000, 4'(i), res, rtag, z, n, c, lat, ill);
            check($sformatf("op%0d_result", i), 32'(res), 32'(exp_res[i]));
            check($sformatf("op%0d_carry", i), 32'(c), 32'(exp_c[i]));
            check($sformatf("op%0d_latency", i), 32'(lat), 2);
        end
        check("asr_neg", 32'(n), 1);

        do_req(3'b000, 4'd1, 16'h0001, 4'd5, res, rtag, z, n, c, lat, ill);
        check("zero_result", 32'(res), 0);
        check("zero_flag", 32'(z), 1);
        check("zero_carry", 32'(c), 1);

        do_req(3'b001, 4'd0, 16'h8000, 4'd6, res, rtag, z, n, c, lat, ill);
        check("amt0_result", 32'(res), 32'h8000);
        check("amt0_neg", 32'(n), 1);
        check("amt0_carry", 32'(c), 0);

        do_req(3'b110, 4'd7, 16'h1234, 4'd9, res, rtag, z, n, c, lat, ill);
        check("illegal_result", 32'(res), 32'h1234);
        check("illegal_carry", 32'(c), 0);
        check("illegal_tag", 32'(rtag), 9);
        check("illegal_pulse_count", 32'(ill), 1);

        // Backpressure: four requests against a stalled consumer
        OutReady = 1'b0; idx = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge Clk); #1;
            InValid = (idx < 4);
            InTag = 4'(idx + 1); InOp = 3'(idx % 5); InAmount = 4'(idx + 3); InOperand = 16'hA5C3 ^ 16'(idx);
            @(negedge Clk);
            if (InValid && InReady) idx++;
        end
        check("bp_accepted", 32'(idx), 2);
        check("bp_in_ready", 32'(InReady), 0);
        @(posedge Clk); #1 OutReady = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge Clk);
            if (OutValid && OutReady) got.push_back(int'(OutTag));
            if (InValid && InReady) idx++;
            @(posedge Clk); #1;
            InValid = (idx < 4);
            InTag = 4'(idx + 1); InOp = 3'(idx % 5); InAmount = 4'(idx + 3); InOperand = 16'hA5C3 ^ 16'(idx);
        end
        InValid = 1'b0;
        check("bp_count", 32'(got.size()), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_order%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(i + 1));

        // Reset with both stages occupied
        OutReady = 1'b0; idx = 0;
        for (int cyc = 0; cyc < 6 && idx < 2; cyc++) begin
            @(posedge Clk); #1;
            InValid = 1'b1; InTag = 4'(10 + idx); InOp = 3'd1; InAmount = 4'd2; InOperand = 16'h0F0F;
            @(negedge Clk);
            if (InValid && InReady) idx++;
        end
        @(posedge Clk); #1;
        InValid = 1'b0;
        @(negedge Clk);
        check("mid_full", 32'(InReady), 0);
        @(posedge Clk); #1 ResetN = 1'b0;
        @(posedge Clk); #1 ResetN = 1'b1; OutReady = 1'b1;
        @(negedge Clk);
        check("mid_rst_valid", 32'(OutValid), 0);
        check("mid_rst_ready", 32'(InReady), 1);
        check("mid_rst_outputs", {11'd0, OutResult, OutTag, OutZero, OutNeg, OutCarry, IllegalOp}, 0);
        highs = 0;
        repeat (8) begin @(negedge Clk); highs += int'(OutValid); end
        check("mid_rst_no_emit", 32'(highs), 0);

        // Randomized traffic, occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge Clk);
            acc = InValid && InReady && ResetN;
            @(posedge Clk); #1;
            ResetN   = ($urandom_range(0, 299) != 0);
            OutReady = ($urandom_range(0, 3) != 0);
            if (acc || !InValid) begin
                InValid   = ($urandom_range(0, 2) != 0);
                InOp      = 3'($urandom_range(0, 7));
                InAmount  = 4'($urandom_range(0, 15));
                InOperand = 16'($urandom);
                InTag     = 4'($urandom);
            end
        end
        @(posedge Clk); #1;
        ResetN = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        check("drain_empty", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
